eco32f_sync_fifo: RTL
=====================

# eco32f_sync_fifo

Single-clock first-word-fall-through FIFO that owns both ports of an `eco32f_simple_dpram_sclk` storage array. It is the writer and the reader for that RAM. Producers push via a valid/ready handshake and consumers pop via valid/ready. It is used for the store buffer and for the bus response queues between the pipeline and the memory interface.

## Interface
- `DEPTH_WIDTH`, default 4: log2 of capacity; capacity = 2^DEPTH_WIDTH entries.
- `DATA_WIDTH`, default 32: entry width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all contents.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO accepts data this cycle.
- `in_data`  in  DATA_WIDTH  push data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer takes head this cycle.
- `out_data`  out  DATA_WIDTH  head entry.
- `level`  out  DEPTH_WIDTH+1  occupancy (see Configuration).

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each DEPTH_WIDTH+1 bits; the MSB is the wrap bit.
  - Empty: `wr_ptr == rd_ptr`.
  - Full: low bits equal and MSBs differ.
- Handshake signals:
  - `in_ready = !full && !flush`.
  - push = `in_valid && in_ready`.
  - `out_valid = !empty_r` (registered, see Timing).
  - pop = `out_valid && out_ready && !flush`.
- On push: RAM `we=1`, `waddr=wr_ptr[DEPTH_WIDTH-1:0]`, `din=in_data`; `wr_ptr` increments, wrapping modulo 2^(DEPTH_WIDTH+1).
- Reads: RAM `re=1` every cycle, with `raddr = (rd_ptr + pop)` low bits. This prefetches the next head, so a pop produces no bubble.
- Write-to-read collision: the RAM is instantiated with `ENABLE_BYPASS=1`. A push to the address being read in the same cycle returns the new data.
- On pop: `rd_ptr` increments.
- Push while full is not accepted, because `in_ready=0`. There is no pass-through: a full FIFO with a simultaneous pop still rejects the push that cycle.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- `flush`:
  - Next edge: `wr_ptr=rd_ptr=0`, `out_valid=0`.
  - A concurrent push or pop is ignored.
- Out-of-range guard: `out_data` is forced to 0 whenever `out_valid=0`.

## Timing
- Reset values, while `rst` is high and after it is released:
  - `wr_ptr=rd_ptr=0`
  - `out_valid=0`
  - `out_data=0`
  - `in_ready=1` (0 if `flush` is high)
  - `level=0`
- Push-to-out latency: data pushed at edge N into an empty FIFO gives `out_valid=1` with that data after edge N (one cycle).
- Pop: the head advances at the same edge; the next entry is valid in the following cycle with no bubble.
- Registered vs combinational outputs:
  - `in_ready` is combinational from full and `flush` only; it never depends on `in_valid`.
  - `out_valid` is registered.
- Sustained throughput is one push and one pop per cycle.
- `rst` asserted mid-transfer discards everything immediately (asynchronous); there is no partial write visible afterward.

## Configuration
- `ECO32F_FIFO_LEVEL_EN` defined: `level = wr_ptr - rd_ptr` (registered, modulo 2^(DEPTH_WIDTH+1)), ranging 0..2^DEPTH_WIDTH, updated on the same edge as the pointers.
- Undefined: `level` is tied to 0 and the subtractor is omitted. All other behaviour is identical.

## Structure
- Shared package `eco32f_pkg`: pointer-width helper constant (`DEPTH_WIDTH+1`) and the flag macro name.
- One sub-module: `eco32f_simple_dpram_sclk` with `ADDR_WIDTH=DEPTH_WIDTH`, `DATA_WIDTH=DATA_WIDTH`, `ENABLE_BYPASS=1`.
- Pointer and flag logic stay in this block.

## Test plan
- Reset, then push 0xA5 with `out_ready=0`: `out_valid=1` one cycle later, `out_data=0xA5`, `level=1`.
- Fill a DEPTH_WIDTH=2 FIFO with 1,2,3,4: `in_ready=0` after the 4th push, and a 5th push (0x55) is not stored. Drain to get 1,2,3,4 in order, then `out_valid=0` and `out_data=0`.
- Continuous push and pop of 0..99 with both readies high: output matches 0..99 with no gaps and `level` stays 1. This exercises pointer wrap at 2^DEPTH_WIDTH and read/write collision bypass.
- Full FIFO with `in_valid=1` and `out_ready=1` in the same cycle: pop occurs, push is rejected, and `level` goes from 4 to 3.
- Three entries queued, then `flush` with concurrent `in_valid`/`out_ready`: next cycle `out_valid=0`, `level=0`, and a subsequent push of 0x77 is the head.
- Assert `rst` asynchronously between edges while 2 entries are queued: outputs go immediately to their reset values and no stale data appears after release.

Source files
------------

// File: rtl/eco32f_pkg.sv
// Shared definitions for the eco32f FIFO slice.
//   ptr_width()       : width of a FIFO pointer (address bits plus one wrap bit)
//   FIFO_LEVEL_MACRO  : name of the build flag that enables the occupancy output
package eco32f_pkg;

  localparam string FIFO_LEVEL_MACRO = "ECO32F_FIFO_LEVEL_EN";

  function automatic int unsigned ptr_width(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/eco32f_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
//   clk   : clock, rising edge
//   we    : write enable; waddr/din give the write address and data
//   re    : read enable; raddr gives the read address, dout is registered
// With ENABLE_BYPASS != 0, a write and a read to the same address in the same
// cycle return the newly written data on dout.
module eco32f_simple_dpram_sclk #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      if ((ENABLE_BYPASS != 0) && we && (waddr == raddr)) begin
        dout <= din;
      end else begin
        dout <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/eco32f_sync_fifo.sv
// Single-clock first-word-fall-through FIFO built on eco32f_simple_dpram_sclk.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   flush               : synchronous clear of all contents
//   in_valid/in_ready   : push handshake, in_data is the pushed entry
//   out_valid/out_ready : pop handshake, out_data is the head entry (0 when empty)
//   level               : occupancy, only when ECO32F_FIFO_LEVEL_EN is defined
//                         (tied to 0 otherwise)
// Build flag: ECO32F_FIFO_LEVEL_EN
module eco32f_sync_fifo
  import eco32f_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEPTH_WIDTH:0]  level
);

  localparam int unsigned PW = ptr_width(DEPTH_WIDTH);

  logic [PW-1:0]          wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic                   empty_r, full, push, pop;
  logic [DATA_WIDTH-1:0]  ram_dout;
  logic [DEPTH_WIDTH-1:0] raddr;

  assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty_r;
  assign pop       = out_valid && out_ready && !flush;

  assign wr_nxt = wr_ptr + PW'(push);
  assign rd_nxt = rd_ptr + PW'(pop);

  // Read the entry that will be the head after this edge, so a pop is
  // followed by the next entry without a bubble.
  assign raddr = rd_ptr[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_r <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_r <= 1'b1;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      empty_r <= (wr_nxt == rd_nxt);
    end
  end

`ifdef ECO32F_FIFO_LEVEL_EN
  logic [DEPTH_WIDTH:0] level_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= '0;
    end else if (flush) begin
      level_r <= '0;
    end else begin
      level_r <= wr_nxt - rd_nxt;
    end
  end

  assign level = level_r;
`else
  assign level = '0;
`endif

  eco32f_simple_dpram_sclk #(
    .ADDR_WIDTH   (DEPTH_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ENABLE_BYPASS(1)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[DEPTH_WIDTH-1:0]),
    .din  (in_data),
    .re   (1'b1),
    .raddr(raddr),
    .dout (ram_dout)
  );

  // The RAM output is meaningless while empty; never expose it.
  assign out_data = out_valid ? ram_dout : '0;

endmodule
